// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   IFQ_INSN_W  : instruction width
//   IFQ_PC_W    : program-counter width
//   IFQ_ENTRY_W : width of one queue entry, {insn, pc4}
//   PC_RESET    : PC value loaded on reset
//   ifq_entry_t : packed layout of one queue entry
//   pc_plus4()  : sequential-PC helper; it wraps modulo 2^32
package ifetch_queue_pkg;

    localparam int IFQ_INSN_W  = 32;
    localparam int IFQ_PC_W    = 32;
    localparam int IFQ_ENTRY_W = IFQ_INSN_W + IFQ_PC_W;

    localparam logic [IFQ_PC_W-1:0] PC_RESET = 32'h0000_0000;

    typedef struct packed {
        logic [IFQ_INSN_W-1:0] insn;
        logic [IFQ_PC_W-1:0]   pc4;
    } ifq_entry_t;

    // The sum naturally wraps 0xFFFFFFFC -> 0x00000000.
    function automatic logic [IFQ_PC_W-1:0] pc_plus4(input logic [IFQ_PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and dispatch.
//   imem_ren/imem_addr      : fetch request (queue -> memory)
//   imem_rdata              : instruction, valid the cycle after imem_ren
//   ifetch_intruction/pc_4  : head entry of the queue (queue -> dispatch)
//   ifetch_empty            : queue empty; the head outputs are don't-care
//   Dispatch_ren            : pop the head entry
//   Dispatch_jmp/_jmp_addr  : flush the queue and redirect the PC
// modport master : the fetch queue itself
// modport slave  : the memory/dispatch side
interface ifetch_queue_if
    import ifetch_queue_pkg::*;
#(
    parameter int IMEM_AW = 8
);
    logic                  imem_ren;
    logic [IMEM_AW-1:0]    imem_addr;
    logic [IFQ_INSN_W-1:0] imem_rdata;
    logic [IFQ_INSN_W-1:0] ifetch_intruction;
    logic [IFQ_PC_W-1:0]   ifetch_pc_4;
    logic                  ifetch_empty;
    logic                  Dispatch_ren;
    logic                  Dispatch_jmp;
    logic [IFQ_PC_W-1:0]   Dispatch_jmp_addr;

    modport master (
        output imem_ren, imem_addr, ifetch_intruction, ifetch_pc_4, ifetch_empty,
        input  imem_rdata, Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr
    );

    modport slave (
        input  imem_ren, imem_addr, ifetch_intruction, ifetch_pc_4, ifetch_empty,
        output imem_rdata, Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   wr_en/wr_data: push one word
//   rd_en        : pop the head word; it is ignored while the FIFO is empty
//   flush        : empty the FIFO; it dominates a simultaneous push or pop
//   rd_data      : head word; it reads as zero while the FIFO is empty
//   count/empty  : occupancy
// DEPTH must be a power of two, so the pointers wrap on their own.
module ifetch_queue_fifo
    import ifetch_queue_pkg::*;
#(
    parameter  int WIDTH = IFQ_ENTRY_W,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage has no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A simultaneous push and pop leave count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end. It holds the PC and issues reads to a memory with
// 1-cycle read latency. It also queues {instruction, PC+4} pairs for dispatch.
//   clock, reset  : rising-edge clock, asynchronous active-low reset
//   bus (master)  : memory request/return, queue head, and dispatch pop/jump
//   ifq_flush_cnt : saturating count of jump cycles (only with IFQ_PERF_CNT_EN)
// Optional feature macro: IFQ_PERF_CNT_EN
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int IMEM_AW = 8
)(
    input  logic            clock,
    input  logic            reset,
    ifetch_queue_if.master  bus
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [15:0]     ifq_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [IFQ_PC_W-1:0] pc;
    logic [IFQ_PC_W-1:0] jmp_pc;
    logic                inflight;
    logic [IFQ_PC_W-1:0] inflight_pc4;
    logic                issue;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         occupancy;
    logic                fifo_empty;
    ifq_entry_t          wr_entry;
    ifq_entry_t          head;

    // Entries already queued plus the one read in flight must leave room for
    // that read. Because of this, a returning word is never dropped.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue     = reset && !bus.Dispatch_jmp && (occupancy < (CW+1)'(DEPTH));
    assign jmp_pc    = bus.Dispatch_jmp_addr & ~32'h3;

    assign bus.imem_ren  = issue;
    assign bus.imem_addr = pc[IMEM_AW+1:2];

    // The returning word is tagged with the PC+4 of the fetch that requested it.
    assign wr_entry = '{insn: bus.imem_rdata, pc4: inflight_pc4};

    // A jump clears inflight, so the word returning on the next cycle is never
    // written. A flush also wins over a return that lands in the jump cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc           <= PC_RESET;
            inflight     <= 1'b0;
            inflight_pc4 <= '0;
        end else if (bus.Dispatch_jmp) begin
            pc           <= jmp_pc;
            inflight     <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc           <= pc_plus4(pc);
                inflight_pc4 <= pc_plus4(pc);
            end
        end
    end

    ifetch_queue_fifo #(
        .WIDTH (IFQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data (wr_entry),
        .rd_en   (bus.Dispatch_ren),
        .flush   (bus.Dispatch_jmp),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign bus.ifetch_intruction = head.insn;
    assign bus.ifetch_pc_4       = head.pc4;
    assign bus.ifetch_empty      = fifo_empty;

`ifdef IFQ_PERF_CNT_EN
    // Counts every cycle in which a jump is asserted. The count sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifq_flush_cnt <= '0;
        end else if (bus.Dispatch_jmp && (ifq_flush_cnt != 16'hFFFF)) begin
            ifq_flush_cnt <= ifq_flush_cnt + 16'd1;
        end
    end
`endif

endmodule
